// File: rtl/cpu_alu_pkg.sv
// Shared types for the sequential ALU: op codes, control states and width helpers.
package cpu_alu_pkg;

  typedef enum logic [2:0] {
    SUM = 3'd0,
    AND = 3'd1,
    OR  = 3'd2,
    EOR = 3'd3,
    SR  = 3'd4
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    ADJ  = 1'b1
  } alu_state_t;

  // Number of 4-bit digits in an operand of the given width.
  function automatic int nib(input int width);
    return width / 4;
  endfunction

endpackage

// File: rtl/cpu_alu_seq_bcd_adjust.sv
// Combinational decimal correction of a binary sum/difference, one nibble at a time.
module bcd_adjust
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   bin_in,
  input  logic [WIDTH/4-1:0] nib_carry,
  input  logic               subtract,
  output logic [WIDTH-1:0]   adj_out,
  output logic               adj_carry
);

  localparam int NIB = nib(WIDTH);

  logic [4:0] digit_s;
  logic       ac_s;

  // Ripple from the low digit: add 6 on overflow or >9, or take 6 off a digit that borrowed.
  always_comb begin
    adj_out = '0;
    digit_s = 5'd0;
    ac_s    = 1'b0;
    for (int k = 0; k < NIB; k++) begin
      if (subtract) begin
        digit_s = {1'b0, bin_in[4*k +: 4]} - (nib_carry[k] ? 5'd0 : 5'd6);
      end else begin
        digit_s = {1'b0, bin_in[4*k +: 4]} + {4'd0, ac_s};
        digit_s = digit_s + ((nib_carry[k] || (digit_s > 5'd9)) ? 5'd6 : 5'd0);
        ac_s    = digit_s[4];
      end
      adj_out[4*k +: 4] = digit_s[3:0];
    end
    adj_carry = ac_s;
  end

endmodule

// File: rtl/cpu_alu_seq.sv
// Handshaked ALU with registered result and C/Z/V/N/H flags; decimal SUM takes an extra
// adjust cycle, every other operation completes in one.
module cpu_alu_seq
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit DECIMAL_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_ai,
  input  logic [WIDTH-1:0] i_bi,
  input  logic             i_inv_b,
  input  logic             i_carry_in,
  input  logic             i_decimal,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_c,
  output logic             o_z,
  output logic             o_v,
  output logic             o_n,
  output logic             o_h
);

  localparam int NIB = nib(WIDTH);
  localparam int MSB = WIDTH - 1;

  alu_op_t          op_s;
  logic [WIDTH-1:0] be_s;
  logic [WIDTH:0]   sum_s;
  logic [NIB-1:0]   nc_s;
  logic [WIDTH-1:0] res_s;
  logic             c_s;
  logic             v_s;
  logic             h_s;
  logic             accept_s;
  logic             dec_s;
  logic [WIDTH-1:0] adj_s;
  logic             adj_c_s;

  alu_state_t       state_r;
  logic [WIDTH-1:0] work_r;
  logic [NIB-1:0]   nib_c_r;
  logic             bin_c_r;
  logic             sub_r;
  logic             z_p_r;
  logic             n_p_r;
  logic             v_p_r;
  logic             h_p_r;

  assign op_s     = alu_op_t'(i_op);
  assign be_s     = i_inv_b ? ~i_bi : i_bi;
  assign sum_s    = {1'b0, i_ai} + {1'b0, be_s} + {{WIDTH{1'b0}}, i_carry_in};
  assign accept_s = i_valid && o_ready;
  assign dec_s    = (DECIMAL_EN != 1'b0) && (op_s == SUM) && i_decimal;

  // Carry out of each nibble: recovered from the sum bit just above it.
  always_comb begin
    nc_s = '0;
    for (int k = 0; k < NIB - 1; k++) begin
      nc_s[k] = sum_s[4*k+4] ^ i_ai[4*k+4] ^ be_s[4*k+4];
    end
    nc_s[NIB-1] = sum_s[WIDTH];
  end

  // Per-op result and op-specific flags; unknown codes fall back to AND.
  always_comb begin
    res_s = i_ai & be_s;
    c_s   = i_carry_in;
    v_s   = 1'b0;
    h_s   = 1'b0;
    case (op_s)
      SUM: begin
        res_s = sum_s[MSB:0];
        c_s   = sum_s[WIDTH];
        h_s   = nc_s[0];
        v_s   = (i_ai[MSB] == be_s[MSB]) && (sum_s[MSB] != i_ai[MSB]);
      end
      AND:     res_s = i_ai & be_s;
      OR:      res_s = i_ai | be_s;
      EOR:     res_s = i_ai ^ be_s;
      SR: begin
        res_s = {i_carry_in, i_ai[MSB:1]};
        c_s   = i_ai[0];
      end
      default: res_s = i_ai & be_s;
    endcase
  end

  bcd_adjust #(.WIDTH(WIDTH)) u_adj (
    .bin_in    (work_r),
    .nib_carry (nib_c_r),
    .subtract  (sub_r),
    .adj_out   (adj_s),
    .adj_carry (adj_c_s)
  );

  // Control FSM and result/flag registers; decimal flags wait in z/n/v/h_p_r until ADJ ends.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= IDLE;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_c      <= 1'b0;
      o_z      <= 1'b0;
      o_v      <= 1'b0;
      o_n      <= 1'b0;
      o_h      <= 1'b0;
      work_r   <= '0;
      nib_c_r  <= '0;
      bin_c_r  <= 1'b0;
      sub_r    <= 1'b0;
      z_p_r    <= 1'b0;
      n_p_r    <= 1'b0;
      v_p_r    <= 1'b0;
      h_p_r    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && dec_s) begin
            state_r <= ADJ;
            o_ready <= 1'b0;
            work_r  <= res_s;
            nib_c_r <= nc_s;
            bin_c_r <= c_s;
            sub_r   <= i_inv_b;
            z_p_r   <= (res_s == '0);
            n_p_r   <= res_s[MSB];
            v_p_r   <= v_s;
            h_p_r   <= h_s;
          end else if (accept_s) begin
            o_result <= res_s;
            o_c      <= c_s;
            o_z      <= (res_s == '0);
            o_v      <= v_s;
            o_n      <= res_s[MSB];
            o_h      <= h_s;
            o_valid  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        ADJ: begin
          o_result <= adj_s;
          o_c      <= sub_r ? bin_c_r : (bin_c_r | adj_c_s);
          o_z      <= z_p_r;
          o_v      <= v_p_r;
          o_n      <= n_p_r;
          o_h      <= h_p_r;
          o_valid  <= 1'b1;
          o_ready  <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_alu_seq.sv
// Drives an 8-bit and a 16-bit cpu_alu_seq with identical requests and checks both
// against an arithmetic reference model.
module tb_cpu_alu_seq;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        z;
    logic        v;
    logic        n;
    logic        h;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [2:0]  op;
  logic [15:0] ai;
  logic [15:0] bi;
  logic        inv;
  logic        cin;
  logic        dec;

  logic        rdy8, vld8, c8, z8, v8, n8, h8;
  logic [7:0]  res8;
  logic        rdy16, vld16, c16, z16, v16, n16, h16;
  logic [15:0] res16;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  cpu_alu_seq #(.WIDTH(8), .DECIMAL_EN(1'b1)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy8), .i_op(op),
    .i_ai(ai[7:0]), .i_bi(bi[7:0]), .i_inv_b(inv), .i_carry_in(cin), .i_decimal(dec),
    .o_valid(vld8), .o_result(res8), .o_c(c8), .o_z(z8), .o_v(v8), .o_n(n8), .o_h(h8)
  );

  cpu_alu_seq #(.WIDTH(16), .DECIMAL_EN(1'b1)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy16), .i_op(op),
    .i_ai(ai), .i_bi(bi), .i_inv_b(inv), .i_carry_in(cin), .i_decimal(dec),
    .o_valid(vld16), .o_result(res16), .o_c(c16), .o_z(z16), .o_v(v16), .o_n(n16), .o_h(h16)
  );

  function automatic int bcd2int(input int x, input int w);
    int val = 0;
    int p = 1;
    for (int i = 0; i < w / 4; i++) begin
      val = val + ((x >> (4 * i)) & 15) * p;
      p = p * 10;
    end
    return val;
  endfunction

  function automatic int int2bcd(input int x, input int w);
    int val = 0;
    int rem = x;
    for (int i = 0; i < w / 4; i++) begin
      val = val | ((rem % 10) << (4 * i));
      rem = rem / 10;
    end
    return val;
  endfunction

  // Reference: binary results from integer arithmetic, decimal results from digit values.
  function automatic exp_t model(input int w, input logic [2:0] o, input logic [15:0] a,
                                 input logic [15:0] b, input logic iv, input logic ci,
                                 input logic d);
    exp_t e;
    int mask, half, aa, bb, be, s, sa, sb, t, r, c, v, h, dv, md, cc;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    aa = int'(a) & mask;
    bb = int'(b) & mask;
    be = iv ? (bb ^ mask) : bb;
    cc = ci ? 1 : 0;
    c = cc; v = 0; h = 0; r = 0;
    case (o)
      3'd0: begin
        s = aa + be + cc;
        r = s & mask;
        c = (s >> w) & 1;
        h = (((aa & 15) + (be & 15) + cc) > 15) ? 1 : 0;
        sa = (aa >= half) ? aa - 2 * half : aa;
        sb = (be >= half) ? be - 2 * half : be;
        t = sa + sb + cc;
        v = (t >= half || t < -half) ? 1 : 0;
      end
      3'd2: r = aa | be;
      3'd3: r = aa ^ be;
      3'd4: begin
        r = (cc != 0 ? half : 0) | (aa >> 1);
        c = aa & 1;
      end
      default: r = aa & be;
    endcase
    e.z = (r == 0);
    e.n = (r >= half);
    e.v = (v != 0);
    e.h = (h != 0);
    if (o == 3'd0 && d) begin
      md = 1;
      for (int i = 0; i < w / 4; i++) md = md * 10;
      if (!iv) begin
        dv = bcd2int(aa, w) + bcd2int(bb, w) + cc;
        c = (dv >= md) ? 1 : 0;
        r = int2bcd(dv % md, w);
      end else begin
        dv = bcd2int(aa, w) - bcd2int(bb, w) - (1 - cc);
        c = (dv >= 0) ? 1 : 0;
        if (dv < 0) dv = dv + md;
        r = int2bcd(dv, w);
      end
    end
    e.r = r[15:0];
    e.c = (c != 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e8, input exp_t e16);
    chk({tag, " res8"}, {24'd0, res8}, {16'd0, e8.r});
    chk({tag, " flags8"}, {27'd0, c8, z8, v8, n8, h8}, {27'd0, e8.c, e8.z, e8.v, e8.n, e8.h});
    chk({tag, " res16"}, {16'd0, res16}, {16'd0, e16.r});
    chk({tag, " flags16"}, {27'd0, c16, z16, v16, n16, h16},
        {27'd0, e16.c, e16.z, e16.v, e16.n, e16.h});
  endtask

  task automatic set_in(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic iv, input logic ci, input logic d);
    op = o; ai = a; bi = b; inv = iv; cin = ci; dec = d; valid = 1'b1;
  endtask

  // One request end to end: latency, ready during ADJ, then the result and flags.
  task automatic run(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                     input logic iv, input logic ci, input logic d, input string tag);
    exp_t e8, e16;
    int lat, want;
    e8 = model(8, o, a, b, iv, ci, d);
    e16 = model(16, o, a, b, iv, ci, d);
    want = (d && o == 3'd0) ? 2 : 1;
    @(negedge clk);
    set_in(o, a, b, iv, ci, d);
    @(negedge clk);
    valid = 1'b0;
    lat = 1;
    chk({tag, " ready"}, {30'd0, rdy8, rdy16}, (want == 2) ? 32'd0 : 32'd3);
    while (!(vld8 && vld16) && lat < 4) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, want);
    chk_out(tag, e8, e16);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] x;
    for (int i = 0; i < 4; i++) x[4*i +: 4] = 4'($urandom_range(0, 9));
    return x;
  endfunction

  initial begin
    exp_t e1_8, e1_16, e2_8, e2_16, z_e;
    logic [2:0]  ro;
    logic [15:0] ra, rb;
    logic        rd;
    z_e = '0;
    rst_n = 1'b0;
    valid = 1'b0; op = 3'd0; ai = 16'd0; bi = 16'd0; inv = 1'b0; cin = 1'b0; dec = 1'b0;

    // Reset state, during and just after reset.
    repeat (2) @(negedge clk);
    chk("rst ready/valid", {28'd0, rdy8, rdy16, vld8, vld16}, 32'hC);
    chk_out("rst", z_e, z_e);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst valid", {30'd0, vld8, vld16}, 32'd0);

    // Directed arithmetic, logic and shift cases.
    run(3'd0, 16'h0050, 16'h0050, 1'b0, 1'b0, 1'b0, "sum 50+50");
    run(3'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, "sum 7fff+1");
    run(3'd0, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0, "sub 0-1");
    run(3'd0, 16'h0019, 16'h0028, 1'b0, 1'b0, 1'b1, "dec 19+28");
    run(3'd0, 16'h0099, 16'h0001, 1'b0, 1'b0, 1'b1, "dec 99+01");
    run(3'd0, 16'h0999, 16'h0001, 1'b0, 1'b0, 1'b1, "dec 0999+1");
    run(3'd0, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b1, "dec 00-01");
    run(3'd4, 16'h0081, 16'h0000, 1'b0, 1'b1, 1'b0, "sr 81 c1");
    run(3'd4, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, "sr 01 c0");
    run(3'd2, 16'hA0A0, 16'h0505, 1'b0, 1'b0, 1'b1, "or dec-ignored");
    run(3'd7, 16'hF0F0, 16'h3C3C, 1'b0, 1'b1, 1'b0, "undef op");

    // Outputs hold through idle cycles.
    e1_8 = model(8, 3'd7, 16'hF0F0, 16'h3C3C, 1'b0, 1'b1, 1'b0);
    e1_16 = model(16, 3'd7, 16'hF0F0, 16'h3C3C, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold valid", {30'd0, vld8, vld16}, 32'd0);
    chk_out("hold", e1_8, e1_16);

    // Back-to-back binary ops with no gap.
    e1_8 = model(8, 3'd0, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0);
    e1_16 = model(16, 3'd0, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0);
    e2_8 = model(8, 3'd1, 16'h00F0, 16'h003C, 1'b0, 1'b0, 1'b0);
    e2_16 = model(16, 3'd1, 16'h00F0, 16'h003C, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_in(3'd0, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b first valid", {30'd0, vld8, vld16}, 32'd3);
    chk_out("b2b first", e1_8, e1_16);
    set_in(3'd1, 16'h00F0, 16'h003C, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    valid = 1'b0;
    chk("b2b second valid", {30'd0, vld8, vld16}, 32'd3);
    chk_out("b2b second", e2_8, e2_16);

    // Held request during ADJ is taken exactly once, after ADJ.
    e1_8 = model(8, 3'd0, 16'h0019, 16'h0028, 1'b0, 1'b0, 1'b1);
    e1_16 = model(16, 3'd0, 16'h0019, 16'h0028, 1'b0, 1'b0, 1'b1);
    e2_8 = model(8, 3'd3, 16'h1234, 16'h00FF, 1'b0, 1'b0, 1'b0);
    e2_16 = model(16, 3'd3, 16'h1234, 16'h00FF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_in(3'd0, 16'h0019, 16'h0028, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    set_in(3'd3, 16'h1234, 16'h00FF, 1'b0, 1'b0, 1'b0);
    chk("held adj ready", {28'd0, rdy8, rdy16, vld8, vld16}, 32'd0);
    @(negedge clk);
    chk("held dec done", {28'd0, rdy8, rdy16, vld8, vld16}, 32'hF);
    chk_out("held dec", e1_8, e1_16);
    @(negedge clk);
    valid = 1'b0;
    chk("held second valid", {30'd0, vld8, vld16}, 32'd3);
    chk_out("held second", e2_8, e2_16);
    @(negedge clk);
    chk("held no repeat", {30'd0, vld8, vld16}, 32'd0);

    // Reset during ADJ discards the operation.
    @(negedge clk);
    set_in(3'd0, 16'h0045, 16'h0055, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst ready/valid", {28'd0, rdy8, rdy16, vld8, vld16}, 32'hC);
    chk_out("midrst", z_e, z_e);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst no valid", {28'd0, rdy8, rdy16, vld8, vld16}, 32'hC);
    end
    chk_out("midrst after", z_e, z_e);

    // Randomized mix, including undefined codes and decimal add/subtract.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rd = 1'($urandom_range(0, 1));
      if (ro == 3'd0 && rd) begin
        ra = rand_bcd();
        rb = rand_bcd();
      end else begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end
      run(ro, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
